// File: rtl/md_pkg.sv
// Shared encodings for the P6 multiply/divide controller: MD op codes, FSM states
// and the result constants used by the divider's corner cases.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;
    localparam logic [2:0] MD_MADD  = 3'b110;
    localparam logic [2:0] MD_RSVD  = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [31:0] DIV_ZERO_Q   = 32'hFFFFFFFF;
    localparam logic [31:0] OVERFLOW_Q   = 32'h80000000;
    localparam logic [31:0] MINUS_ONE    = 32'hFFFFFFFF;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// EX-stage request/response bundle between the pipeline (master) and the
// multiply/divide controller (slave).
interface mult_div_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        md_stall;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, md_stall, done, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, md_stall, done, HI, LO
    );
endinterface

// File: rtl/md_div_core.sv
// Combinational 32-bit quotient/remainder, signed or unsigned, with the MIPS-style
// divide-by-zero and INT_MIN / -1 results folded in so callers never see X or traps.
module md_div_core
    import md_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    // SV signed division truncates toward zero and % follows the dividend's sign,
    // which is exactly the MIPS convention once the two traps are filtered out.
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (divisor == '0) begin
            quotient  = DIV_ZERO_Q;
            remainder = dividend;
        end else if (is_signed && dividend == OVERFLOW_Q && divisor == MINUS_ONE) begin
            quotient  = OVERFLOW_Q;
            remainder = '0;
        end else if (is_signed) begin
            quotient  = $signed(dividend) / $signed(divisor);
            remainder = $signed(dividend) % $signed(divisor);
        end else begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle MD controller owning HI/LO; results are computed at the start edge and
// released after a fixed latency. Optional madd via `define MULT_DIV_MADD_EN.
module mult_div_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_ctrl_if.slave md
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0]  state;
    logic [3:0]  count;
    logic [31:0] sh_hi, sh_lo;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        is_mul, is_div, is_madd, is_arith;
    logic [63:0] prod_s, prod_u;
    logic [31:0] div_q, div_r;
    logic [31:0] res_hi, res_lo;

    assign is_mul  = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
    assign is_div  = (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
`ifdef MULT_DIV_MADD_EN
    assign is_madd = (md.md_op == MD_MADD);
`else
    assign is_madd = 1'b0;
`endif
    assign is_arith = is_mul || is_div || is_madd;

    // Low 64 bits of the sign-extended product equal the exact signed product.
    assign prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign prod_u = {32'b0, md.A} * {32'b0, md.B};

    md_div_core u_div (
        .dividend  (md.A),
        .divisor   (md.B),
        .is_signed (md.md_op == MD_DIV),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md.md_op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV,
            MD_DIVU:  begin
                res_hi = div_r;
                res_lo = div_q;
            end
`ifdef MULT_DIV_MADD_EN
            MD_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
`endif
            default:  ;
        endcase
    end

    // Requests (including mthi/mtlo) are only honoured from IDLE; the hazard unit
    // holds later MD instructions in ID via md_stall while RUN is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            sh_hi  <= '0;
            sh_lo  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (md.start) begin
                        if (is_arith) begin
                            sh_hi <= res_hi;
                            sh_lo <= res_lo;
                            count <= is_div ? DIV_LOAD : MULT_LOAD;
                            state <= ST_RUN;
                        end else if (md.md_op == MD_MTHI) begin
                            hi_q <= md.A;
                        end else if (md.md_op == MD_MTLO) begin
                            lo_q <= md.A;
                        end
                    end
                end
                ST_RUN: begin
                    if (count == 4'd1) begin
                        hi_q   <= sh_hi;
                        lo_q   <= sh_lo;
                        done_q <= 1'b1;
                        count  <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md.busy     = (state == ST_RUN);
    assign md.md_stall = md.busy || (md.start && is_arith);
    assign md.done     = done_q;
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl (default latencies 5/10);
// the madd scenario is compiled in when MULT_DIV_MADD_EN is defined.
module tb_mult_div_ctrl;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mult_div_ctrl_if md ();

    mult_div_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample 1ns later; every request is one cycle wide.
    task automatic step();
        @(posedge clk);
        #1;
        md.start = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start = 1'b1;
        md.md_op = op;
        md.A     = a;
        md.B     = b;
        #1;
    endtask

    task automatic wait_idle(output int cycles, output bit stall_ok);
        cycles   = 0;
        stall_ok = 1'b1;
        while (md.busy === 1'b1 && cycles < 40) begin
            if (md.md_stall !== 1'b1) stall_ok = 1'b0;
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b, expected 0", md.busy); end
        n_cmp++; if (md.done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b, expected 0", md.done); end
        n_cmp++; if (md.HI !== 32'h0) begin n_err++; $display("[TB] FAIL reset_hi: got %h, expected 00000000", md.HI); end
        n_cmp++; if (md.LO !== 32'h0) begin n_err++; $display("[TB] FAIL reset_lo: got %h, expected 00000000", md.LO); end
        n_cmp++; if (md.md_stall !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall: got %b, expected 0", md.md_stall); end
    endtask

    // Table of full arithmetic operations with hand-computed HI/LO and latency.
    task automatic test_arith();
        logic [2:0]  ops [8]  = '{MD_MULT, MD_MULTU, MD_DIVU, MD_DIV, MD_DIV, MD_DIV, MD_DIVU, MD_MULT};
        logic [31:0] av  [8]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'd5,
                                  32'h80000000, 32'd5, 32'h00010000};
        logic [31:0] bv  [8]  = '{32'd3, 32'hFFFFFFFF, 32'd7, 32'd2, 32'd0,
                                  32'hFFFFFFFF, 32'd0, 32'hFFFF0000};
        logic [31:0] ehi [8]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'd5,
                                  32'h0, 32'd5, 32'hFFFFFFFF};
        logic [31:0] elo [8]  = '{32'hFFFFFFFA, 32'h00000001, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        int          elat[8]  = '{5, 5, 10, 10, 10, 10, 10, 5};
        int          cycles;
        bit          stall_ok;
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], av[i], bv[i]);
            n_cmp++; if (md.md_stall !== 1'b1) begin n_err++; $display("[TB] FAIL arith%0d_start_stall: got %b, expected 1", i, md.md_stall); end
            step();
            md.A = 32'hDEADBEEF;
            md.B = 32'h00000001;
            wait_idle(cycles, stall_ok);
            n_cmp++; if (cycles !== elat[i]) begin n_err++; $display("[TB] FAIL arith%0d_latency: got %0d, expected %0d", i, cycles, elat[i]); end
            n_cmp++; if (stall_ok !== 1'b1) begin n_err++; $display("[TB] FAIL arith%0d_busy_stall: got %b, expected 1", i, stall_ok); end
            n_cmp++; if (md.done !== 1'b1) begin n_err++; $display("[TB] FAIL arith%0d_done: got %b, expected 1", i, md.done); end
            n_cmp++; if (md.HI !== ehi[i]) begin n_err++; $display("[TB] FAIL arith%0d_hi: got %h, expected %h", i, md.HI, ehi[i]); end
            n_cmp++; if (md.LO !== elo[i]) begin n_err++; $display("[TB] FAIL arith%0d_lo: got %h, expected %h", i, md.LO, elo[i]); end
            step();
            n_cmp++; if (md.done !== 1'b0) begin n_err++; $display("[TB] FAIL arith%0d_done_width: got %b, expected 0", i, md.done); end
        end
    endtask

    task automatic test_move();
        drive(MD_MTLO, 32'h00000055, 32'h0);
        n_cmp++; if (md.md_stall !== 1'b0) begin n_err++; $display("[TB] FAIL mtlo_stall: got %b, expected 0", md.md_stall); end
        step();
        n_cmp++; if (md.LO !== 32'h55) begin n_err++; $display("[TB] FAIL mtlo_lo: got %h, expected 00000055", md.LO); end
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL mtlo_busy: got %b, expected 0", md.busy); end
        n_cmp++; if (md.done !== 1'b0) begin n_err++; $display("[TB] FAIL mtlo_done: got %b, expected 0", md.done); end
        drive(MD_MTHI, 32'hA5A5A5A5, 32'h0);
        step();
        n_cmp++; if (md.HI !== 32'hA5A5A5A5) begin n_err++; $display("[TB] FAIL mthi_hi: got %h, expected a5a5a5a5", md.HI); end
        n_cmp++; if (md.LO !== 32'h55) begin n_err++; $display("[TB] FAIL mthi_lo_kept: got %h, expected 00000055", md.LO); end
    endtask

    task automatic test_reserved();
        drive(MD_RSVD, 32'h11111111, 32'h22222222);
        n_cmp++; if (md.md_stall !== 1'b0) begin n_err++; $display("[TB] FAIL rsvd_stall: got %b, expected 0", md.md_stall); end
        step();
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rsvd_busy: got %b, expected 0", md.busy); end
        n_cmp++; if ({md.HI, md.LO} !== {32'hA5A5A5A5, 32'h55}) begin n_err++; $display("[TB] FAIL rsvd_hilo: got %h_%h, expected a5a5a5a5_00000055", md.HI, md.LO); end
`ifndef MULT_DIV_MADD_EN
        drive(MD_MADD, 32'h3, 32'h4);
        n_cmp++; if (md.md_stall !== 1'b0) begin n_err++; $display("[TB] FAIL madd_off_stall: got %b, expected 0", md.md_stall); end
        step();
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL madd_off_busy: got %b, expected 0", md.busy); end
        n_cmp++; if ({md.HI, md.LO} !== {32'hA5A5A5A5, 32'h55}) begin n_err++; $display("[TB] FAIL madd_off_hilo: got %h_%h, expected a5a5a5a5_00000055", md.HI, md.LO); end
`endif
    endtask

    // mtlo issued in the second busy cycle must be dropped; operands change too.
    task automatic test_busy_ignore();
        int cycles;
        bit stall_ok;
        drive(MD_MULT, 32'd6, 32'd7);
        step();
        n_cmp++; if (md.md_stall !== 1'b1) begin n_err++; $display("[TB] FAIL ign_c1_stall: got %b, expected 1", md.md_stall); end
        step();
        drive(MD_MTLO, 32'h00001234, 32'h00000009);
        n_cmp++; if (md.md_stall !== 1'b1) begin n_err++; $display("[TB] FAIL ign_c2_stall: got %b, expected 1", md.md_stall); end
        step();
        wait_idle(cycles, stall_ok);
        n_cmp++; if (cycles !== 3) begin n_err++; $display("[TB] FAIL ign_remaining: got %0d, expected 3", cycles); end
        n_cmp++; if (stall_ok !== 1'b1) begin n_err++; $display("[TB] FAIL ign_busy_stall: got %b, expected 1", stall_ok); end
        n_cmp++; if (md.LO !== 32'd42) begin n_err++; $display("[TB] FAIL ign_lo: got %h, expected 0000002a", md.LO); end
        n_cmp++; if (md.HI !== 32'd0) begin n_err++; $display("[TB] FAIL ign_hi: got %h, expected 00000000", md.HI); end
        step();
        n_cmp++; if (md.LO !== 32'd42) begin n_err++; $display("[TB] FAIL ign_lo_late: got %h, expected 0000002a", md.LO); end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        drive(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", md.busy); end
        n_cmp++; if ({md.HI, md.LO} !== 64'h0) begin n_err++; $display("[TB] FAIL rstmid_hilo: got %h_%h, expected 00000000_00000000", md.HI, md.LO); end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (md.done !== 1'b0 || md.busy !== 1'b0) saw_done = 1'b1;
            step();
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_no_done: got %b, expected 0", saw_done); end
        n_cmp++; if ({md.HI, md.LO} !== 64'h0) begin n_err++; $display("[TB] FAIL rstmid_hilo_late: got %h_%h, expected 00000000_00000000", md.HI, md.LO); end
        drive(MD_MTHI, 32'd9, 32'd0);
        step();
        n_cmp++; if (md.HI !== 32'd9) begin n_err++; $display("[TB] FAIL rstmid_mthi: got %h, expected 00000009", md.HI); end
        n_cmp++; if (md.busy !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_mthi_busy: got %b, expected 0", md.busy); end
    endtask

`ifdef MULT_DIV_MADD_EN
    task automatic test_madd();
        int cycles;
        bit stall_ok;
        drive(MD_MTHI, 32'h0, 32'h0);
        step();
        drive(MD_MTLO, 32'hFFFFFFFF, 32'h0);
        step();
        drive(MD_MADD, 32'd1, 32'd1);
        n_cmp++; if (md.md_stall !== 1'b1) begin n_err++; $display("[TB] FAIL madd_start_stall: got %b, expected 1", md.md_stall); end
        step();
        wait_idle(cycles, stall_ok);
        n_cmp++; if (cycles !== 5) begin n_err++; $display("[TB] FAIL madd_latency: got %0d, expected 5", cycles); end
        n_cmp++; if (md.HI !== 32'd1) begin n_err++; $display("[TB] FAIL madd_hi: got %h, expected 00000001", md.HI); end
        n_cmp++; if (md.LO !== 32'd0) begin n_err++; $display("[TB] FAIL madd_lo: got %h, expected 00000000", md.LO); end
        n_cmp++; if (md.done !== 1'b1) begin n_err++; $display("[TB] FAIL madd_done: got %b, expected 1", md.done); end
        step();
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        md.start = 1'b0;
        md.md_op = MD_RSVD;
        md.A     = '0;
        md.B     = '0;
        $display("[TB] mult_div_ctrl directed tests");
        test_reset();
        test_arith();
        test_move();
        test_reserved();
        test_busy_ignore();
        test_reset_mid();
`ifdef MULT_DIV_MADD_EN
        test_madd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multi-cycle multiply/divide controller for the P6 pipelined MIPS core; sits in EX beside the ALU.
- Owns the HI/LO registers.
- Sequences mult/multu/div/divu over a fixed latency and handles mthi/mtlo.
- Drives busy/stall so the hazard unit can hold mfhi/mflo and further MD instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  EX-stage MD instruction valid this cycle
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd (optional feature only), 111 reserved
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  operation in progress
- md_stall  out  1  combinational: busy | (start & md_op in {mult,multu,div,divu,madd})
- done  out  1  one-cycle pulse when HI/LO commit
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset: state IDLE, counter 0, busy=0, done=0, HI=0, LO=0.
  - Applies mid-operation: the pending result is discarded and HI/LO are cleared.
- States: IDLE, RUN.
- IDLE, start & arithmetic op:
  - Latch result into shadow regs {sh_hi, sh_lo} at this edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - busy=1, counter decrements each cycle.
  - When counter==1: next edge writes HI<=sh_hi, LO<=sh_lo, pulses done, returns to IDLE.
- Timing: start sampled at edge 0 gives busy=1 for exactly N cycles. New HI/LO and done=1 are visible in the first cycle with busy=0.
- mult: signed 64-bit product, HI=[63:32], LO=[31:0]. multu: unsigned product.
- div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: LO=32'hFFFFFFFF, HI=A (both signed and unsigned).
- Signed overflow 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthi/mtlo in IDLE: HI<=A or LO<=A at the next edge. No busy, no done.
- start while busy: ignored entirely, including mthi/mtlo. The pipeline guarantees this via md_stall; the bench checks HI/LO are unaffected.
- md_op 111, or 110 without the optional feature: ignored, no state change.
- Operands are sampled only at the start edge. Changes to A/B during RUN have no effect.

Optional Feature:
- Macro MULT_DIV_MADD_EN.
- Defined: md_op 110 (madd) is legal.
  - Shadow = {HI,LO} + signed(A)*signed(B), computed from HI/LO at the start edge, mod 2^64.
  - Latency MULT_CYCLES; counts in md_stall.
- Undefined: 110 is treated as reserved and the accumulate adder is absent.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULT..MD_MADD
  - state encodings ST_IDLE/ST_RUN
  - div-by-zero constant 32'hFFFFFFFF
  - overflow constant 32'h80000000
- One natural sub-module, md_div_core: combinational signed/unsigned quotient/remainder with the divide-by-zero and overflow corner cases, unit-testable alone.
- Counter, FSM and HI/LO stay in mult_div_ctrl.

Test Plan:
- mult A=32'hFFFFFFFE (-2), B=3 -> busy high 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, done pulse 1 cycle.
- divu A=100, B=7 -> busy 10 cycles; LO=14, HI=2. div A=-7, B=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- div A=5, B=0 -> LO=32'hFFFFFFFF, HI=5. div A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- mult running, cycle 2: start mtlo A=32'h1234 -> ignored; final LO is the product. md_stall=1 for every busy cycle and on the start cycle.
- multu A=B=32'hFFFFFFFF, reset asserted at cycle 3 -> next cycle busy=0, HI=LO=0, no done pulse. Then mthi A=9 -> HI=9 next cycle, busy stays 0.
- (MULT_DIV_MADD_EN) HI=0, LO=32'hFFFFFFFF; madd A=1, B=1 -> after 5 cycles HI=1, LO=0.
